// File: rtl/mem_stage.sv
// Memory-access stage of the sequential Y86-64 datapath: decodes the access at
// start, moves one 64-bit word as eight little-endian byte beats, reports valM/stat.
module mem_stage #(
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  icode,
    input  logic [63:0] valE,
    input  logic [63:0] valA,
    input  logic [63:0] valP,
    output logic        busy,
    output logic        done,
    output logic [63:0] valM,
    output logic [1:0]  stat,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] STAT_AOK = 2'b00;
    localparam logic [1:0] STAT_HLT = 2'b01;
    localparam logic [1:0] STAT_ADR = 2'b10;
    localparam logic [1:0] STAT_INS = 2'b11;

    state_t      state_q, state_d;
    logic [2:0]  beat_q, beat_d;
    logic [60:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic        rd_q, rd_d;
    logic [63:0] shadow_q, shadow_d;
    logic [63:0] valm_q, valm_d;
    logic [1:0]  stat_q, stat_d;

    logic        dec_acc_s;
    logic        dec_we_s;
    logic [63:0] dec_addr_s;
    logic [63:0] dec_data_s;
    logic [1:0]  dec_stat_s;
    logic        dec_adr_err_s;

    // Instruction decode: access kind, word address, store data and static status
    always_comb begin
        dec_acc_s  = 1'b0;
        dec_we_s   = 1'b0;
        dec_addr_s = valE;
        dec_data_s = valA;
        dec_stat_s = STAT_AOK;
        case (icode)
            4'h5: dec_acc_s = 1'b1;
            4'h9, 4'hB: begin
                dec_acc_s  = 1'b1;
                dec_addr_s = valA;
            end
            4'h4, 4'hA: begin
                dec_acc_s = 1'b1;
                dec_we_s  = 1'b1;
            end
            4'h8: begin
                dec_acc_s  = 1'b1;
                dec_we_s   = 1'b1;
                dec_data_s = valP;
            end
            4'h0: dec_stat_s = STAT_HLT;
            4'h1, 4'h2, 4'h3, 4'h6, 4'h7: dec_stat_s = STAT_AOK;
            default: dec_stat_s = STAT_INS;
        endcase
    end

    // Full 64-bit compare so huge addresses cannot alias into range
    assign dec_adr_err_s = dec_acc_s && (dec_addr_s >= 64'(MEM_WORDS));

    // Next-state logic for the access sequencer
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        rd_d     = rd_q;
        shadow_d = shadow_q;
        valm_d   = valm_q;
        stat_d   = stat_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d  = dec_addr_s[60:0];
                    wdata_d = dec_data_s;
                    we_d    = dec_we_s;
                    beat_d  = 3'd0;
                    if (dec_acc_s && !dec_adr_err_s) begin
                        state_d = S_XFER;
                        rd_d    = !dec_we_s;
                    end else begin
                        state_d = S_DONE;
                        rd_d    = 1'b0;
                        stat_d  = dec_adr_err_s ? STAT_ADR : dec_stat_s;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_XFER: begin
                if (mem_ack) begin
                    if (!we_q) begin
                        shadow_d[{beat_q, 3'b000} +: 8] = mem_rdata;
                    end else begin
                        shadow_d = shadow_q;
                    end
                    beat_d = beat_q + 3'd1;
                    if (beat_q == 3'd7) begin
                        state_d = S_DONE;
                        stat_d  = STAT_AOK;
                    end else begin
                        state_d = S_XFER;
                    end
                end else begin
                    state_d = S_XFER;
                end
            end
            S_DONE: begin
                if (rd_q) begin
                    valm_d = shadow_q;
                end else begin
                    valm_d = valm_q;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            beat_q   <= 3'd0;
            addr_q   <= 61'd0;
            wdata_q  <= 64'd0;
            we_q     <= 1'b0;
            rd_q     <= 1'b0;
            shadow_q <= 64'd0;
            valm_q   <= 64'd0;
            stat_q   <= STAT_AOK;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            rd_q     <= rd_d;
            shadow_q <= shadow_d;
            valm_q   <= valm_d;
            stat_q   <= stat_d;
        end
    end

    // Outputs decode straight from state so reset drops mem_req immediately
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign mem_req   = (state_q == S_XFER);
    assign mem_we    = mem_req & we_q;
    assign mem_addr  = {addr_q, beat_q};
    assign mem_wdata = wdata_q[{beat_q, 3'b000} +: 8];
    assign valM      = valm_q;
    assign stat      = stat_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: byte-memory responder with selectable wait
// patterns, word-level reference model, directed cases then randomized traffic.
module tb_mem_stage;

    localparam int unsigned MW = 1024;
    localparam int          MB = 8192;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  icode;
    logic [63:0] valE, valA, valP;
    logic        busy, done;
    logic [63:0] valM;
    logic [1:0]  stat;
    logic        mem_req, mem_we;
    logic [63:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  mem [0:MB-1];
    int          ack_mode = 0;
    logic        tog = 1'b0;
    int          beat_cnt = 0;
    logic [63:0] m_valm = 64'd0;
    logic [1:0]  m_stat = 2'b00;

    always #5 clk = ~clk;

    mem_stage #(.MEM_WORDS(MW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .icode(icode),
        .valE(valE), .valA(valA), .valP(valP),
        .busy(busy), .done(done), .valM(valM), .stat(stat),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory responder: ack pattern per mode, read data from the byte array
    always @(negedge clk) begin
        if (mem_req) begin
            case (ack_mode)
                0: mem_ack = 1'b1;
                1: begin mem_ack = tog; tog = ~tog; end
                default: mem_ack = ($urandom_range(0, 2) != 0);
            endcase
        end else begin
            tog = 1'b0;
            mem_ack = (ack_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        mem_rdata = mem[mem_addr[12:0]];
    end

    // Completed beats: count them and commit write bytes to memory
    always @(posedge clk) begin
        if (rst_n && mem_req && mem_ack) begin
            if (mem_we) mem[mem_addr[12:0]] = mem_wdata;
            beat_cnt++;
        end
    end

    // Reference: what the instruction should do, at word level
    task automatic model(input logic [3:0] ic, input logic [63:0] e, a, p,
                         output logic acc, output logic wr,
                         output logic [63:0] wa, output logic [63:0] dat,
                         output logic [1:0] st);
        acc = 1'b0; wr = 1'b0; wa = e; dat = a; st = 2'b00;
        if (ic == 4'h0) st = 2'b01;
        else if (ic > 4'hB) st = 2'b11;
        else if (ic == 4'h5) acc = 1'b1;
        else if (ic == 4'h9 || ic == 4'hB) begin acc = 1'b1; wa = a; end
        else if (ic == 4'h4 || ic == 4'hA) begin acc = 1'b1; wr = 1'b1; end
        else if (ic == 4'h8) begin acc = 1'b1; wr = 1'b1; dat = p; end
        if (acc && wa >= 64'(MW)) begin acc = 1'b0; wr = 1'b0; st = 2'b10; end
    endtask

    task automatic run_txn(input logic [3:0] ic, input logic [63:0] e, a, p,
                           input int mode, input bit glitch);
        logic acc, wr;
        logic [63:0] wa, dat, exp_word;
        logic [1:0] st;
        int cyc, b0;
        bit got;
        model(ic, e, a, p, acc, wr, wa, dat, st);
        exp_word = 64'd0;
        if (acc && !wr)
            for (int k = 7; k >= 0; k--) exp_word = (exp_word << 8) | 64'(mem[wa * 8 + k]);
        ack_mode = mode;
        icode = ic; valE = e; valA = a; valP = p; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        b0 = beat_cnt; cyc = 1; got = 1'b0;
        while (!got && cyc < 400) begin
            if (glitch && cyc == 3) begin
                start = 1'b1; icode = 4'h4; valE = 64'd7; valA = {$urandom, $urandom};
            end else begin
                start = 1'b0;
            end
            chk("busy", 64'(busy), 64'd1);
            if (done) begin
                got = 1'b1;
                chk("stat_at_done", 64'(stat), 64'(st));
                chk("valM_before_update", valM, m_valm);
                chk("req_in_done", 64'(mem_req), 64'd0);
                if (mode != 2 || !acc)
                    chk("latency", 64'(cyc), acc ? ((mode == 0) ? 64'd9 : 64'd17) : 64'd1);
            end else if (acc) begin
                chk("req", 64'(mem_req), 64'd1);
                chk("addr", mem_addr, wa * 8 + 64'(beat_cnt - b0));
                chk("we", 64'(mem_we), 64'(wr));
                if (wr) chk("wdata", 64'(mem_wdata), (dat >> (8 * (beat_cnt - b0))) & 64'hff);
            end else begin
                chk("noacc_done_next", 64'(done), 64'd1);
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        if (!got) chk("timeout", 64'd0, 64'd1);
        if (acc && !wr) m_valm = exp_word;
        m_stat = st;
        chk("valM_after", valM, m_valm);
        chk("stat_hold", 64'(stat), 64'(m_stat));
        chk("busy_after", 64'(busy), 64'd0);
        chk("done_pulse", 64'(done), 64'd0);
        if (acc && wr)
            for (int k = 0; k < 8; k++)
                chk("mem_written", 64'(mem[wa * 8 + k]), (dat >> (8 * k)) & 64'hff);
    endtask

    task automatic reset_mid();
        int b0, n;
        ack_mode = 0;
        icode = 4'h5; valE = 64'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        b0 = beat_cnt; n = 0;
        while (beat_cnt - b0 < 3 && n < 50) begin @(negedge clk); n++; end
        chk("rst_reach_beat3", 64'(beat_cnt - b0), 64'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_req", 64'(mem_req), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_valM", valM, 64'd0);
        chk("rst_stat", 64'(stat), 64'd0);
        m_valm = 64'd0; m_stat = 2'b00;
        @(negedge clk);
        chk("rst_no_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    function automatic logic [63:0] pick_addr();
        if ($urandom_range(0, 9) == 0) return {$urandom, $urandom};
        return 64'($urandom_range(0, MW + 3));
    endfunction

    initial begin
        logic [3:0]  ic;
        logic [63:0] e, a;
        for (int i = 0; i < MB; i++) mem[i] = 8'($urandom);
        for (int k = 0; k < 8; k++) mem[16 + k] = 8'(k + 1);
        rst_n = 1'b0; start = 1'b0; icode = 4'h0;
        valE = 64'd0; valA = 64'd0; valP = 64'd0;
        mem_ack = 1'b0; mem_rdata = 8'd0;
        @(negedge clk); @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_valM", valM, 64'd0);
        chk("reset_stat", 64'(stat), 64'd0);
        chk("reset_req", 64'(mem_req), 64'd0);
        chk("reset_we", 64'(mem_we), 64'd0);
        chk("reset_addr", mem_addr, 64'd0);
        chk("reset_wdata", 64'(mem_wdata), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_txn(4'h5, 64'd2, 64'd0, 64'd0, 0, 1'b0);
        chk("mrmovq_value", valM, 64'h0807060504030201);
        run_txn(4'h8, 64'd10, 64'd0, 64'h1122334455667788, 1, 1'b0);
        chk("call_byte80", 64'(mem[80]), 64'h88);
        chk("call_byte87", 64'(mem[87]), 64'h11);
        run_txn(4'h6, 64'd5, 64'd5, 64'd0, 0, 1'b0);
        chk("noacc_keeps_valM", valM, 64'h0807060504030201);
        run_txn(4'hB, 64'd0, 64'(MW), 64'd0, 0, 1'b0);
        chk("adr_stat", 64'(stat), 64'h2);
        run_txn(4'h0, 64'd0, 64'd0, 64'd0, 0, 1'b0);
        chk("hlt_stat", 64'(stat), 64'h1);
        run_txn(4'hC, 64'd0, 64'd0, 64'd0, 0, 1'b0);
        chk("ins_stat", 64'(stat), 64'h3);
        run_txn(4'h5, 64'd2, 64'd0, 64'd0, 0, 1'b1);
        reset_mid();
        run_txn(4'h5, 64'd2, 64'd0, 64'd0, 0, 1'b0);
        chk("load_after_reset", valM, 64'h0807060504030201);
        run_txn(4'hA, 64'd40, 64'hdeadbeefcafef00d, 64'd0, 2, 1'b0);
        run_txn(4'hB, 64'd0, 64'd40, 64'd0, 2, 1'b0);
        chk("push_pop_value", valM, 64'hdeadbeefcafef00d);

        for (int i = 0; i < 60; i++) begin
            ic = 4'($urandom_range(0, 15));
            e  = pick_addr();
            a  = (ic == 4'h9 || ic == 4'hB) ? pick_addr() : {$urandom, $urandom};
            run_txn(ic, e, a, {$urandom, $urandom}, int'($urandom_range(0, 2)),
                    1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
